// File: rtl/spi_flash_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_flash_pkg : opcodes and FSM state type for the SPI flash responder
// Rev 1.0
// ---------------------------------------------------------------------------
package spi_flash_pkg;

   localparam logic [7:0] OP_READ      = 8'h03;
   localparam logic [7:0] OP_FAST_READ = 8'h0B;
   localparam logic [7:0] OP_RDID      = 8'h9F;
   localparam logic [7:0] OP_RDSR      = 8'h05;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      ADDR   = 3'd2,
      DUMMY  = 3'd3,
      DATA   = 3'd4,
      IGNORE = 3'd5
   } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_flash_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_flash_mem : 1W/1R byte array with registered read (old data on collision)
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_flash_mem #(
   parameter int          AW    = 13,
   parameter int unsigned DEPTH = 8192
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [0:DEPTH-1];
   logic       wr_ok;

   // Non power-of-two bank counts leave a hole at the top of the address map.
   generate
      if (DEPTH == (2 ** AW)) begin : g_full_map
         assign wr_ok = we;
      end else begin : g_partial_map
         assign wr_ok = we && (32'(waddr) < DEPTH);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (wr_ok) mem[waddr] <= wdata;
      if (re)    rdata <= mem[raddr];
   end

endmodule
`default_nettype wire

// File: rtl/spi_flash_resp_model.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_flash_resp_model : oversampled SPI NOR-flash responder (READ/FAST_READ/RDID/RDSR)
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_flash_resp_model
   import spi_flash_pkg::*;
#(
   parameter int          NUM_CS    = 2,
   parameter int          ADDR_W    = 12,
   parameter int          DUMMY_CYC = 8,
   parameter logic [23:0] JEDEC_ID  = 24'h20BA18
) (
   input  logic                             sys_clk,
   input  logic                             sys_rst,
   input  logic                             spi_sck,
   input  logic [NUM_CS-1:0]                spi_cs_n,
   input  logic                             spi_mosi,
   output logic                             spi_miso,
   output logic                             spi_miso_oe,
   input  logic                             ld_we,
   input  logic [$clog2(NUM_CS)+ADDR_W-1:0] ld_addr,
   input  logic [7:0]                       ld_data,
   output logic                             busy,
   output logic                             cmd_err,
   output logic [7:0]                       last_op
);

   localparam int          BANK_W  = $clog2(NUM_CS);
   localparam int          BANK_RW = (BANK_W > 0) ? BANK_W : 1;
   localparam int          MEM_AW  = BANK_W + ADDR_W;
   localparam int          SH_W    = (ADDR_W > 8) ? ADDR_W : 8;
   localparam int unsigned DEPTH   = NUM_CS * (2 ** ADDR_W);

   logic              sck_s1, sck_s2, sck_d;
   logic              mosi_s1, mosi_s2;
   logic [NUM_CS-1:0] cs_s1, cs_s2;
   logic              cs_high_d;

   state_e              state;
   logic [4:0]          bit_cnt;
   logic [SH_W-2:0]     sh;
   logic [7:0]          op;
   logic [ADDR_W-1:0]   addr;
   logic [BANK_RW-1:0]  bank;
   logic [7:0]          out_sh;
   logic                load_pend;
   logic                from_mem;
   logic [7:0]          pend_byte;
   logic [1:0]          id_idx;
   logic                rd_en;
   logic [ADDR_W-1:0]   rd_off;
   logic [MEM_AW-1:0]   rd_addr;
   logic [7:0]          mem_rdata;

   logic                rise, fall, all_high, cs_fall, multi_low;
   logic [2:0]          low_cnt;
   logic [BANK_RW-1:0]  low_idx;
   logic [SH_W-1:0]     sh_next;
   logic [ADDR_W-1:0]   addr_in;

   // CS sync flops reset to "selected" so a bus that is mid-transfer at reset
   // never looks like a fresh CS fall; only a full rise re-arms the responder.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sck_s1    <= 1'b0;
         sck_s2    <= 1'b0;
         sck_d     <= 1'b0;
         mosi_s1   <= 1'b0;
         mosi_s2   <= 1'b0;
         cs_s1     <= '0;
         cs_s2     <= '0;
         cs_high_d <= 1'b0;
      end else begin
         sck_s1    <= spi_sck;
         sck_s2    <= sck_s1;
         sck_d     <= sck_s2;
         mosi_s1   <= spi_mosi;
         mosi_s2   <= mosi_s1;
         cs_s1     <= spi_cs_n;
         cs_s2     <= cs_s1;
         cs_high_d <= &cs_s2;
      end
   end

   assign rise     = sck_s2 & ~sck_d;
   assign fall     = ~sck_s2 & sck_d;
   assign all_high = &cs_s2;
   assign cs_fall  = cs_high_d & ~all_high;
   assign sh_next  = {sh, mosi_s2};
   assign addr_in  = sh_next[ADDR_W-1:0];

   always_comb begin
      low_cnt = '0;
      low_idx = '0;
      for (int i = 0; i < NUM_CS; i++) begin
         if (!cs_s2[i]) begin
            low_cnt = low_cnt + 3'd1;
            low_idx = BANK_RW'(i);
         end
      end
   end

   assign multi_low = (low_cnt > 3'd1);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         sh        <= '0;
         op        <= '0;
         addr      <= '0;
         bank      <= '0;
         out_sh    <= '0;
         load_pend <= 1'b0;
         from_mem  <= 1'b0;
         pend_byte <= '0;
         id_idx    <= '0;
         rd_en     <= 1'b0;
         rd_off    <= '0;
         cmd_err   <= 1'b0;
         last_op   <= '0;
      end else begin
         cmd_err <= 1'b0;
         rd_en   <= 1'b0;
         if (state != IDLE && all_high) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            load_pend <= 1'b0;
            out_sh    <= '0;
         end else if (state == IDLE) begin
            if (cs_fall) begin
               bit_cnt   <= '0;
               out_sh    <= '0;
               load_pend <= 1'b0;
               id_idx    <= '0;
               if (multi_low) begin
                  cmd_err <= 1'b1;
                  state   <= IGNORE;
               end else begin
                  bank  <= low_idx;
                  state <= CMD;
               end
            end
         end else if (state != IGNORE && multi_low) begin
            cmd_err <= 1'b1;
            state   <= IGNORE;
         end else if (rise) begin
            sh      <= sh_next[SH_W-2:0];
            bit_cnt <= bit_cnt + 5'd1;
            case (state)
               CMD: if (bit_cnt == 5'd7) begin
                  bit_cnt <= '0;
                  op      <= sh_next[7:0];
                  last_op <= sh_next[7:0];
                  case (sh_next[7:0])
                     OP_READ, OP_FAST_READ: state <= ADDR;
                     OP_RDID: begin
                        state     <= DATA;
                        load_pend <= 1'b1;
                        from_mem  <= 1'b0;
                        pend_byte <= JEDEC_ID[23:16];
                        id_idx    <= 2'd1;
                     end
                     OP_RDSR: begin
                        state     <= DATA;
                        load_pend <= 1'b1;
                        from_mem  <= 1'b0;
                        pend_byte <= 8'h00;
                     end
                     default: begin
                        state   <= IGNORE;
                        cmd_err <= 1'b1;
                     end
                  endcase
               end
               ADDR: if (bit_cnt == 5'd23) begin
                  bit_cnt <= '0;
                  if (op == OP_FAST_READ) begin
                     addr  <= addr_in;
                     state <= DUMMY;
                  end else begin
                     rd_en     <= 1'b1;
                     rd_off    <= addr_in;
                     addr      <= addr_in + ADDR_W'(1);
                     load_pend <= 1'b1;
                     from_mem  <= 1'b1;
                     state     <= DATA;
                  end
               end
               DUMMY: if (bit_cnt == 5'(DUMMY_CYC - 1)) begin
                  bit_cnt   <= '0;
                  rd_en     <= 1'b1;
                  rd_off    <= addr;
                  addr      <= addr + ADDR_W'(1);
                  load_pend <= 1'b1;
                  from_mem  <= 1'b1;
                  state     <= DATA;
               end
               DATA: if (bit_cnt == 5'd7) begin
                  bit_cnt   <= '0;
                  load_pend <= 1'b1;
                  if (op == OP_RDID) begin
                     case (id_idx)
                        2'd1:    pend_byte <= JEDEC_ID[15:8];
                        2'd2:    pend_byte <= JEDEC_ID[7:0];
                        default: pend_byte <= 8'h00;
                     endcase
                     if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                  end else if (op == OP_RDSR) begin
                     pend_byte <= 8'h00;
                  end else begin
                     rd_en  <= 1'b1;
                     rd_off <= addr;
                     addr   <= addr + ADDR_W'(1);
                  end
               end
               default: ;
            endcase
         end else if (fall && state == DATA) begin
            if (load_pend) begin
               out_sh    <= from_mem ? mem_rdata : pend_byte;
               load_pend <= 1'b0;
            end else begin
               out_sh <= {out_sh[6:0], 1'b0};
            end
         end
      end
   end

   generate
      if (BANK_W == 0) begin : g_one_bank
         assign rd_addr = rd_off;
      end else begin : g_multi_bank
         assign rd_addr = {bank[BANK_W-1:0], rd_off};
      end
   endgenerate

   spi_flash_mem #(
      .AW    (MEM_AW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (sys_clk),
      .we    (ld_we),
      .waddr (ld_addr),
      .wdata (ld_data),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (mem_rdata)
   );

   // Drive enable drops in the very cycle the synchronised CS rise is seen.
   assign spi_miso_oe = (state == DATA) && !all_high;
   assign spi_miso    = spi_miso_oe & out_sh[7];
   assign busy        = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_resp_model.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_flash_resp_model : randomized SPI master against a flat memory model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_spi_flash_resp_model;

   localparam int HALF = 5;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        spi_sck = 1'b0;
   logic [1:0]  spi_cs_n = 2'b11;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic        spi_miso_oe;
   logic        ld_we = 1'b0;
   logic [12:0] ld_addr = '0;
   logic [7:0]  ld_data = '0;
   logic        busy;
   logic        cmd_err;
   logic [7:0]  last_op;

   int total = 0;
   int bad   = 0;
   int err_cycles = 0;

   logic [7:0] ref_mem [0:1][0:4095];

   spi_flash_resp_model dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .spi_sck     (spi_sck),
      .spi_cs_n    (spi_cs_n),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .ld_we       (ld_we),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .busy        (busy),
      .cmd_err     (cmd_err),
      .last_op     (last_op)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) if (cmd_err === 1'b1) err_cycles <= err_cycles + 1;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic ld(input int b, input int a, input logic [7:0] d);
      @(negedge sys_clk);
      ld_we   = 1'b1;
      ld_addr = {1'(b), 12'(a)};
      ld_data = d;
      ref_mem[b][a] = d;
      @(negedge sys_clk);
      ld_we = 1'b0;
   endtask

   // Clocks hdr (MSB-aligned), dummy and data bits; CS is left low afterwards.
   task automatic xfer(input logic [1:0] cs, input logic [39:0] hdr, input int hdr_bits,
                       input int dummy_bits, input int data_bytes, input bit exp_oe,
                       output logic [63:0] rx, output int oe_bad, output int busy_low);
      rx = '0; oe_bad = 0; busy_low = 0;
      @(negedge sys_clk);
      spi_cs_n = cs;
      repeat (HALF) @(negedge sys_clk);
      for (int i = 0; i < hdr_bits + dummy_bits + 8 * data_bytes; i++) begin
         spi_mosi = (i < hdr_bits) ? hdr[39 - i] : 1'b0;
         repeat (HALF) @(negedge sys_clk);
         if (i >= hdr_bits + dummy_bits) begin
            rx = {rx[62:0], spi_miso};
            if (spi_miso_oe !== exp_oe) oe_bad++;
         end else if (spi_miso_oe !== 1'b0) begin
            oe_bad++;
         end
         if (busy !== 1'b1) busy_low++;
         spi_sck = 1'b1;
         repeat (HALF) @(negedge sys_clk);
         spi_sck = 1'b0;
      end
   endtask

   task automatic cs_release();
      repeat (HALF) @(negedge sys_clk);
      spi_cs_n = 2'b11;
      repeat (8) @(negedge sys_clk);
   endtask

   function automatic logic [63:0] model_read(input int b, input int a, input int len);
      logic [63:0] e = '0;
      for (int k = 0; k < len; k++) e = {e[55:0], ref_mem[b][(a + k) % 4096]};
      return e;
   endfunction

   task automatic test_reset();
      repeat (4) @(negedge sys_clk);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
      total++; if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", spi_miso_oe); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end
      total++; if (last_op !== 8'h00) begin bad++; $display("FAIL reset_last_op: got %h want 00", last_op); end
   endtask

   task automatic preload();
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < 4096; a++) ld(b, a, 8'($urandom));
      ld(0, 16'h010, 8'hA5); ld(0, 16'h011, 8'h5A); ld(0, 16'h012, 8'h3C); ld(0, 16'h013, 8'hC3);
      ld(0, 16'hFFF, 8'h11); ld(0, 16'h000, 8'h22);
   endtask

   task automatic test_read();
      logic [63:0] rx; int oe_bad, bl;
      xfer(2'b10, {8'h03, 24'h000010, 8'h00}, 32, 0, 4, 1'b1, rx, oe_bad, bl);
      cs_release();
      total++; if (rx[31:0] !== 32'hA55A3CC3) begin bad++; $display("FAIL read_t1_data: got %h want A55A3CC3", rx[31:0]); end
      total++; if (oe_bad !== 0) begin bad++; $display("FAIL read_t1_oe: got %0d bad samples want 0", oe_bad); end
      total++; if (last_op !== 8'h03) begin bad++; $display("FAIL read_last_op: got %h want 03", last_op); end
   endtask

   task automatic test_fast_read();
      logic [63:0] rx; int oe_bad, bl;
      xfer(2'b10, {8'h0B, 24'h000FFF, 8'h00}, 32, 8, 2, 1'b1, rx, oe_bad, bl);
      cs_release();
      total++; if (rx[15:0] !== 16'h1122) begin bad++; $display("FAIL fast_wrap_data: got %h want 1122", rx[15:0]); end
      total++; if (bl !== 0) begin bad++; $display("FAIL fast_busy: got %0d low samples want 0", bl); end
      total++; if (oe_bad !== 0) begin bad++; $display("FAIL fast_oe: got %0d bad samples want 0", oe_bad); end
      total++; if (last_op !== 8'h0B) begin bad++; $display("FAIL fast_last_op: got %h want 0B", last_op); end
   endtask

   task automatic test_random_reads();
      logic [63:0] rx, exp; int oe_bad, bl, b, len; logic [11:0] a; bit fast;
      for (int n = 0; n < 10; n++) begin
         b    = $urandom_range(0, 1);
         a    = (n % 2 == 1) ? 12'($urandom_range(4088, 4095)) : 12'($urandom_range(0, 4095));
         len  = $urandom_range(1, 8);
         fast = 1'($urandom_range(0, 1));
         exp  = model_read(b, int'(a), len);
         xfer(~(2'b01 << b), {(fast ? 8'h0B : 8'h03), 12'h000, a, 8'h00}, 32,
              fast ? 8 : 0, len, 1'b1, rx, oe_bad, bl);
         cs_release();
         total++;
         if (rx !== exp || oe_bad != 0) begin
            bad++;
            $display("FAIL rand_read bank=%0d addr=%h len=%0d fast=%0d: got %h want %h (oe_bad=%0d)",
                     b, a, len, fast, rx, exp, oe_bad);
         end
      end
   endtask

   task automatic test_id_status();
      logic [63:0] rx; int oe_bad, bl;
      xfer(2'b10, {8'h9F, 32'h0}, 8, 0, 5, 1'b1, rx, oe_bad, bl);
      cs_release();
      total++; if (rx[39:0] !== 40'h20BA180000) begin bad++; $display("FAIL rdid_data: got %h want 20BA180000", rx[39:0]); end
      total++; if (last_op !== 8'h9F) begin bad++; $display("FAIL rdid_last_op: got %h want 9F", last_op); end
      xfer(2'b01, {8'h05, 32'h0}, 8, 0, 3, 1'b1, rx, oe_bad, bl);
      cs_release();
      total++; if (rx[23:0] !== 24'h0 || oe_bad != 0) begin bad++; $display("FAIL rdsr_data: got %h want 000000", rx[23:0]); end
   endtask

   task automatic test_bad_opcode();
      logic [63:0] rx, exp; int oe_bad, bl, e0; logic [11:0] a;
      e0 = err_cycles;
      xfer(2'b10, {8'h5A, 32'h0}, 8, 0, 2, 1'b0, rx, oe_bad, bl);
      cs_release();
      total++; if (err_cycles - e0 !== 1) begin bad++; $display("FAIL badop_err_pulse: got %0d cycles want 1", err_cycles - e0); end
      total++; if (oe_bad !== 0) begin bad++; $display("FAIL badop_oe: got %0d bad samples want 0", oe_bad); end
      total++; if (last_op !== 8'h5A) begin bad++; $display("FAIL badop_last_op: got %h want 5A", last_op); end
      a   = 12'($urandom_range(0, 4095));
      exp = model_read(1, int'(a), 3);
      xfer(2'b01, {8'h03, 12'h000, a, 8'h00}, 32, 0, 3, 1'b1, rx, oe_bad, bl);
      cs_release();
      total++; if (rx !== exp) begin bad++; $display("FAIL badop_bank1_read: got %h want %h", rx, exp); end
   endtask

   task automatic test_abort();
      logic [63:0] rx; int oe_bad, bl;
      xfer(2'b10, {8'h03, 24'hFFFFFF, 8'h00}, 21, 0, 0, 1'b0, rx, oe_bad, bl);
      cs_release();
      xfer(2'b10, {8'h03, 24'h000010, 8'h00}, 32, 0, 1, 1'b1, rx, oe_bad, bl);
      cs_release();
      total++; if (rx[7:0] !== 8'hA5) begin bad++; $display("FAIL abort_then_read: got %h want A5", rx[7:0]); end
   endtask

   task automatic test_multi_cs_and_reset();
      logic [63:0] rx, exp; int oe_bad, bl, e0;
      e0 = err_cycles;
      xfer(2'b00, {8'h03, 24'h000010, 8'h00}, 32, 0, 1, 1'b0, rx, oe_bad, bl);
      cs_release();
      total++; if (err_cycles - e0 !== 1) begin bad++; $display("FAIL multi_cs_err: got %0d cycles want 1", err_cycles - e0); end
      total++; if (oe_bad !== 0) begin bad++; $display("FAIL multi_cs_oe: got %0d bad samples want 0", oe_bad); end
      xfer(2'b10, {8'h03, 24'h000010, 8'h00}, 32, 0, 1, 1'b1, rx, oe_bad, bl);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      total++;
      if ({spi_miso, spi_miso_oe, busy, cmd_err, last_op} !== 12'h000) begin
         bad++;
         $display("FAIL midrst_outputs: got miso=%b oe=%b busy=%b err=%b op=%h want all 0",
                  spi_miso, spi_miso_oe, busy, cmd_err, last_op);
      end
      @(negedge sys_clk);
      sys_rst = 1'b0;
      xfer(2'b10, {8'h03, 24'h000010, 8'h00}, 32, 0, 2, 1'b0, rx, oe_bad, bl);
      total++; if (oe_bad !== 0 || rx[15:0] !== 16'h0) begin bad++; $display("FAIL midrst_ignored: got oe_bad=%0d data=%h want 0/0000", oe_bad, rx[15:0]); end
      cs_release();
      exp = model_read(0, 16'h010, 2);
      xfer(2'b10, {8'h03, 24'h000010, 8'h00}, 32, 0, 2, 1'b1, rx, oe_bad, bl);
      cs_release();
      total++; if (rx !== exp) begin bad++; $display("FAIL midrst_recover_read: got %h want %h", rx, exp); end
   endtask

   initial begin
      test_reset();
      preload();
      test_read();
      test_fast_read();
      test_random_reads();
      test_id_status();
      test_bad_opcode();
      test_abort();
      test_multi_cs_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
